// File: rtl/bomb_pkg.sv
// Shared types and geometry constants for the bomb scheduler.
package bomb_pkg;

   typedef enum logic [1:0] {
      S_FREE,
      S_ARMED,
      S_EXPLODE,
      S_FLAMES
   } slot_state_t;

   localparam int          BLOCK_SHIFT     = 5;
   localparam logic [10:0] BOMB_CENTER_OFS = 11'd16;
   localparam logic [10:0] BLOCK_SIZE      = 11'd32;

   // Snap the player's centre point to its enclosing block.
   function automatic logic [10:0] block_align(input logic [10:0] v);
      logic [10:0] s;
      s = v + BOMB_CENTER_OFS;
      return {s[10:BLOCK_SHIFT], {BLOCK_SHIFT{1'b0}}};
   endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: lifecycle FSM, fuse/flame countdowns and latched position.
import bomb_pkg::*;

module bomb_slot #(
   parameter int FUSE_SECS  = 3,
   parameter int FLAME_SECS = 1
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        alloc,
   input  logic [10:0] pos_x_in,
   input  logic [10:0] pos_y_in,
   input  logic        tick,
   input  logic        grant,
   input  logic        chain_hit,
   output slot_state_t state,
   output logic [10:0] pos_x,
   output logic [10:0] pos_y
);

   slot_state_t state_nx;
   logic [3:0]  fuse, fuse_nx;
   logic [3:0]  flame, flame_nx;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state <= S_FREE;
         fuse  <= '0;
         flame <= '0;
         pos_x <= '0;
         pos_y <= '0;
      end else begin
         state <= state_nx;
         fuse  <= fuse_nx;
         flame <= flame_nx;
         if (alloc && state == S_FREE) begin
            pos_x <= pos_x_in;
            pos_y <= pos_y_in;
         end
      end
   end

   always_comb begin
      state_nx = state;
      fuse_nx  = fuse;
      flame_nx = flame;
      unique case (state)
         S_FREE:
            if (alloc) begin
               state_nx = S_ARMED;
               fuse_nx  = 4'(FUSE_SECS);
            end
         S_ARMED:
            if (chain_hit) begin
               state_nx = S_EXPLODE;
            end else if (tick) begin
               if (fuse == 4'd1) state_nx = S_EXPLODE;
               else              fuse_nx  = fuse - 4'd1;
            end
         S_EXPLODE:
            if (grant) begin
               state_nx = S_FLAMES;
               flame_nx = 4'(FLAME_SECS);
            end
         S_FLAMES:
            if (tick) begin
               if (flame == 4'd1) state_nx = S_FREE;
               else               flame_nx = flame - 4'd1;
            end
         default: state_nx = S_FREE;
      endcase
   end

endmodule

// File: rtl/bomb_scheduler.sv
// Multi-slot bomb allocator with round-robin wall-destruct arbiter.
// Define BOMB_CHAIN_EN to let an explosion detonate nearby armed bombs.
import bomb_pkg::*;

module bomb_scheduler #(
   parameter int NUM_BOMBS  = 4,
   parameter int FUSE_SECS  = 3,
   parameter int FLAME_SECS = 1
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         enter,
   input  logic [10:0]                  offsetX,
   input  logic [10:0]                  offsetY,
   input  logic                         OneSecPulse,
   output logic [NUM_BOMBS*11-1:0]      bombX,
   output logic [NUM_BOMBS*11-1:0]      bombY,
   output logic [NUM_BOMBS-1:0]         bomb_DrawReq,
   output logic [NUM_BOMBS-1:0]         flames_DrawReq,
   output logic                         enable_wall_destruct,
   output logic [10:0]                  destructX,
   output logic [10:0]                  destructY,
   output logic [$clog2(NUM_BOMBS)-1:0] destruct_slot,
   output logic                         place_reject
);

   localparam int SW = $clog2(NUM_BOMBS);

   logic                 enter_d, req;
   logic [10:0]          tx, ty;
   slot_state_t          st [NUM_BOMBS];
   logic [10:0]          px [NUM_BOMBS];
   logic [10:0]          py [NUM_BOMBS];
   logic [NUM_BOMBS-1:0] alloc, grant, chain, expl;
   logic                 any_free, dup, found;
   logic [SW-1:0]        win, last_grant;

   assign req = enter && !enter_d;
   assign tx  = block_align(offsetX);
   assign ty  = block_align(offsetY);

   for (genvar i = 0; i < NUM_BOMBS; i++) begin : g_slot
      bomb_slot #(
         .FUSE_SECS (FUSE_SECS),
         .FLAME_SECS(FLAME_SECS)
      ) u_slot (
         .clk      (clk),
         .resetN   (resetN),
         .alloc    (alloc[i]),
         .pos_x_in (tx),
         .pos_y_in (ty),
         .tick     (OneSecPulse),
         .grant    (grant[i]),
         .chain_hit(chain[i]),
         .state    (st[i]),
         .pos_x    (px[i]),
         .pos_y    (py[i])
      );
      assign expl[i]            = (st[i] == S_EXPLODE);
      assign bomb_DrawReq[i]    = (st[i] == S_ARMED);
      assign flames_DrawReq[i]  = expl[i] || (st[i] == S_FLAMES);
      assign bombX[i*11 +: 11]  = px[i];
      assign bombY[i*11 +: 11]  = py[i];
   end

   // Lowest free slot wins; any live bomb on the same block vetoes.
   always_comb begin
      alloc    = '0;
      any_free = 1'b0;
      dup      = 1'b0;
      for (int i = 0; i < NUM_BOMBS; i++) begin
         if (st[i] == S_FREE) begin
            if (!any_free) alloc[i] = 1'b1;
            any_free = 1'b1;
         end else if (px[i] == tx && py[i] == ty) begin
            dup = 1'b1;
         end
      end
      if (!req || dup) alloc = '0;
   end

   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      win   = last_grant;
      grant = '0;
      for (int i = 1; i <= NUM_BOMBS; i++) begin
         j = int'(last_grant) + i;
         if (j >= NUM_BOMBS) j = j - NUM_BOMBS;
         if (!found && expl[SW'(j)]) begin
            found = 1'b1;
            win   = SW'(j);
         end
      end
      if (found) grant[win] = 1'b1;
   end

`ifdef BOMB_CHAIN_EN
   function automatic logic near(input logic [10:0] a, input logic [10:0] b);
      logic [10:0] d;
      d = (a >= b) ? a - b : b - a;
      return d <= BLOCK_SIZE;
   endfunction

   always_comb begin
      chain = '0;
      if (found) begin
         for (int i = 0; i < NUM_BOMBS; i++) begin
            if (st[i] == S_ARMED &&
                ((py[i] == py[win] && near(px[i], px[win])) ||
                 (px[i] == px[win] && near(py[i], py[win]))))
               chain[i] = 1'b1;
         end
      end
   end
`else
   assign chain = '0;
`endif

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         enter_d              <= 1'b0;
         place_reject         <= 1'b0;
         enable_wall_destruct <= 1'b0;
         destructX            <= '0;
         destructY            <= '0;
         destruct_slot        <= '0;
         last_grant           <= SW'(NUM_BOMBS - 1);
      end else begin
         enter_d              <= enter;
         place_reject         <= req && (!any_free || dup);
         enable_wall_destruct <= found;
         if (found) begin
            destructX     <= px[win];
            destructY     <= py[win];
            destruct_slot <= win;
            last_grant    <= win;
         end
      end
   end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed self-checking bench for bomb_scheduler (default parameters).
module tb_bomb_scheduler;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          resetN = 1'b0;
   logic          enter = 1'b0;
   logic          OneSecPulse = 1'b0;
   logic [10:0]   offsetX = '0;
   logic [10:0]   offsetY = '0;
   logic [N*11-1:0] bombX, bombY;
   logic [N-1:0]  bomb_DrawReq, flames_DrawReq;
   logic          enable_wall_destruct, place_reject;
   logic [10:0]   destructX, destructY;
   logic [1:0]    destruct_slot;

   int errors = 0;
   int checks = 0;

   bomb_scheduler #(
      .NUM_BOMBS (N),
      .FUSE_SECS (3),
      .FLAME_SECS(1)
   ) dut (
      .clk                 (clk),
      .resetN              (resetN),
      .enter               (enter),
      .offsetX             (offsetX),
      .offsetY             (offsetY),
      .OneSecPulse         (OneSecPulse),
      .bombX               (bombX),
      .bombY               (bombY),
      .bomb_DrawReq        (bomb_DrawReq),
      .flames_DrawReq      (flames_DrawReq),
      .enable_wall_destruct(enable_wall_destruct),
      .destructX           (destructX),
      .destructY           (destructY),
      .destruct_slot       (destruct_slot),
      .place_reject        (place_reject)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      OneSecPulse = 1'b1;
      step();
      OneSecPulse = 1'b0;
   endtask

   task automatic place(input logic [10:0] x, input logic [10:0] y);
      offsetX = x;
      offsetY = y;
      enter   = 1'b0;
      step();
      enter = 1'b1;
      step();
      enter = 1'b0;
   endtask

   task automatic do_reset();
      resetN      = 1'b0;
      enter       = 1'b0;
      OneSecPulse = 1'b0;
      step();
      step();
      resetN = 1'b1;
      step();
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      step();
      checks++;
      if ({bombX, bombY, bomb_DrawReq, flames_DrawReq, enable_wall_destruct,
           destructX, destructY, destruct_slot, place_reject} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got draw=%b flames=%b strobe=%b",
                  bomb_DrawReq, flames_DrawReq, enable_wall_destruct);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      offsetX = 11'd100;
      offsetY = 11'd40;
      enter   = 1'b1;
      step();
      checks++;
      if (bomb_DrawReq !== 4'b0001) begin
         errors++;
         $display("FAIL single_arm got=%b exp=0001", bomb_DrawReq);
      end
      checks++;
      if (bombX[10:0] !== 11'd96 || bombY[10:0] !== 11'd32) begin
         errors++;
         $display("FAIL single_pos got=%0d,%0d exp=96,32",
                  bombX[10:0], bombY[10:0]);
      end
      step();
      step();
      step();
      checks++;
      if (bomb_DrawReq !== 4'b0001 || place_reject !== 1'b0) begin
         errors++;
         $display("FAIL enter_held got=%b rej=%b exp=0001 0",
                  bomb_DrawReq, place_reject);
      end
      enter = 1'b0;
      step();
      tick();
      tick();
      checks++;
      if (bomb_DrawReq !== 4'b0001 || flames_DrawReq !== 4'b0000) begin
         errors++;
         $display("FAIL fuse_2ticks got=%b/%b exp=0001/0000",
                  bomb_DrawReq, flames_DrawReq);
      end
      tick();
      checks++;
      if (flames_DrawReq !== 4'b0001 || bomb_DrawReq !== 4'b0000 ||
          enable_wall_destruct !== 1'b0) begin
         errors++;
         $display("FAIL explode got=%b/%b/%b exp=0001/0000/0",
                  flames_DrawReq, bomb_DrawReq, enable_wall_destruct);
      end
      step();
      checks++;
      if (enable_wall_destruct !== 1'b1 || destructX !== 11'd96 ||
          destructY !== 11'd32 || destruct_slot !== 2'd0) begin
         errors++;
         $display("FAIL strobe0 got=%b %0d,%0d s%0d exp=1 96,32 s0",
                  enable_wall_destruct, destructX, destructY, destruct_slot);
      end
      step();
      checks++;
      if (enable_wall_destruct !== 1'b0 || flames_DrawReq !== 4'b0001) begin
         errors++;
         $display("FAIL strobe_width got=%b fl=%b exp=0 0001",
                  enable_wall_destruct, flames_DrawReq);
      end
      tick();
      checks++;
      if (flames_DrawReq !== 4'b0000 || bomb_DrawReq !== 4'b0000) begin
         errors++;
         $display("FAIL slot_freed got=%b/%b exp=0000/0000",
                  flames_DrawReq, bomb_DrawReq);
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < N; i++) begin
         place(11'(64 * i), 11'd0);
         checks++;
         if (place_reject !== 1'b0) begin
            errors++;
            $display("FAIL full_rej%0d got=%b exp=0", i, place_reject);
         end
      end
      checks++;
      if (bomb_DrawReq !== 4'b1111) begin
         errors++;
         $display("FAIL full_armed got=%b exp=1111", bomb_DrawReq);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (bombX[i*11 +: 11] !== 11'(64 * i)) begin
            errors++;
            $display("FAIL full_x%0d got=%0d exp=%0d",
                     i, bombX[i*11 +: 11], 64 * i);
         end
      end
      place(11'd320, 11'd0);
      checks++;
      if (place_reject !== 1'b1 || bomb_DrawReq !== 4'b1111) begin
         errors++;
         $display("FAIL full_fifth got=%b %b exp=1 1111",
                  place_reject, bomb_DrawReq);
      end
      step();
      checks++;
      if (place_reject !== 1'b0) begin
         errors++;
         $display("FAIL reject_width got=%b exp=0", place_reject);
      end
   endtask

   task automatic test_dup();
      do_reset();
      place(11'd100, 11'd40);
      place(11'd100, 11'd40);
      checks++;
      if (place_reject !== 1'b1 || bomb_DrawReq !== 4'b0001) begin
         errors++;
         $display("FAIL dup_same got=%b %b exp=1 0001",
                  place_reject, bomb_DrawReq);
      end
      place(11'd105, 11'd45);
      checks++;
      if (place_reject !== 1'b1 || bomb_DrawReq !== 4'b0001) begin
         errors++;
         $display("FAIL dup_block got=%b %b exp=1 0001",
                  place_reject, bomb_DrawReq);
      end
      place(11'd140, 11'd40);
      checks++;
      if (place_reject !== 1'b0 || bomb_DrawReq !== 4'b0011) begin
         errors++;
         $display("FAIL dup_other got=%b %b exp=0 0011",
                  place_reject, bomb_DrawReq);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      place(11'd0, 11'd0);
      tick();
      tick();
      place(11'd64, 11'd0);
      place(11'd128, 11'd0);
      tick();
      step();
      checks++;
      if (enable_wall_destruct !== 1'b1 || destruct_slot !== 2'd0) begin
         errors++;
         $display("FAIL rr_first got=%b s%0d exp=1 s0",
                  enable_wall_destruct, destruct_slot);
      end
      tick();
      tick();
      checks++;
      if (flames_DrawReq !== 4'b0110 || enable_wall_destruct !== 1'b0) begin
         errors++;
         $display("FAIL rr_pair got=%b %b exp=0110 0",
                  flames_DrawReq, enable_wall_destruct);
      end
      step();
      checks++;
      if (enable_wall_destruct !== 1'b1 || destruct_slot !== 2'd1 ||
          destructX !== 11'd64) begin
         errors++;
         $display("FAIL rr_s1 got=%b s%0d x%0d exp=1 s1 x64",
                  enable_wall_destruct, destruct_slot, destructX);
      end
      step();
      checks++;
      if (enable_wall_destruct !== 1'b1 || destruct_slot !== 2'd2 ||
          destructX !== 11'd128) begin
         errors++;
         $display("FAIL rr_s2 got=%b s%0d x%0d exp=1 s2 x128",
                  enable_wall_destruct, destruct_slot, destructX);
      end
      step();
      checks++;
      if (enable_wall_destruct !== 1'b0) begin
         errors++;
         $display("FAIL rr_idle got=%b exp=0", enable_wall_destruct);
      end
      place(11'd192, 11'd0);
      place(11'd256, 11'd0);
      checks++;
      if (bomb_DrawReq !== 4'b1001) begin
         errors++;
         $display("FAIL rr_realloc got=%b exp=1001", bomb_DrawReq);
      end
      tick();
      tick();
      tick();
      checks++;
      if (flames_DrawReq !== 4'b1001) begin
         errors++;
         $display("FAIL rr_pair2 got=%b exp=1001", flames_DrawReq);
      end
      step();
      checks++;
      if (enable_wall_destruct !== 1'b1 || destruct_slot !== 2'd3 ||
          destructX !== 11'd256) begin
         errors++;
         $display("FAIL rr_s3 got=%b s%0d x%0d exp=1 s3 x256",
                  enable_wall_destruct, destruct_slot, destructX);
      end
      step();
      checks++;
      if (enable_wall_destruct !== 1'b1 || destruct_slot !== 2'd0 ||
          destructX !== 11'd192) begin
         errors++;
         $display("FAIL rr_wrap got=%b s%0d x%0d exp=1 s0 x192",
                  enable_wall_destruct, destruct_slot, destructX);
      end
   endtask

   task automatic test_chain();
      do_reset();
      place(11'd64, 11'd0);
      tick();
      tick();
      place(11'd96, 11'd0);
      tick();
      checks++;
      if (flames_DrawReq !== 4'b0001) begin
         errors++;
         $display("FAIL chain_pre got=%b exp=0001", flames_DrawReq);
      end
      step();
      checks++;
      if (enable_wall_destruct !== 1'b1 || destructX !== 11'd64) begin
         errors++;
         $display("FAIL chain_first got=%b x%0d exp=1 x64",
                  enable_wall_destruct, destructX);
      end
`ifdef BOMB_CHAIN_EN
      checks++;
      if (flames_DrawReq !== 4'b0011 || bomb_DrawReq !== 4'b0000) begin
         errors++;
         $display("FAIL chain_hit got=%b/%b exp=0011/0000",
                  flames_DrawReq, bomb_DrawReq);
      end
      step();
      checks++;
      if (enable_wall_destruct !== 1'b1 || destructX !== 11'd96 ||
          destruct_slot !== 2'd1) begin
         errors++;
         $display("FAIL chain_second got=%b x%0d s%0d exp=1 x96 s1",
                  enable_wall_destruct, destructX, destruct_slot);
      end
`else
      checks++;
      if (flames_DrawReq !== 4'b0001 || bomb_DrawReq !== 4'b0010) begin
         errors++;
         $display("FAIL no_chain got=%b/%b exp=0001/0010",
                  flames_DrawReq, bomb_DrawReq);
      end
      step();
      checks++;
      if (enable_wall_destruct !== 1'b0) begin
         errors++;
         $display("FAIL no_chain_strobe got=%b exp=0", enable_wall_destruct);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int strobes;
      strobes = 0;
      do_reset();
      place(11'd100, 11'd40);
      tick();
      tick();
      tick();
      checks++;
      if (flames_DrawReq !== 4'b0001) begin
         errors++;
         $display("FAIL mid_pre got=%b exp=0001", flames_DrawReq);
      end
      #2;
      resetN = 1'b0;
      #1;
      checks++;
      if ({bombX, bombY, bomb_DrawReq, flames_DrawReq, enable_wall_destruct,
           destructX, destructY, destruct_slot, place_reject} !== '0) begin
         errors++;
         $display("FAIL mid_reset got fl=%b strobe=%b x%0d",
                  flames_DrawReq, enable_wall_destruct, destructX);
      end
      step();
      step();
      resetN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (enable_wall_destruct === 1'b1) strobes++;
      end
      checks++;
      if (strobes !== 0 || flames_DrawReq !== 4'b0000) begin
         errors++;
         $display("FAIL mid_after got strobes=%0d fl=%b exp=0 0000",
                  strobes, flames_DrawReq);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_dup();
      test_back_to_back();
      test_chain();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
